// File: rtl/maxnet_controller.sv
// Maxnet winner-take-all sequencer for a bank of process units.
// Each iteration pulses load_mult, optionally idles, pulses load_sum, then inspects pu_s.
module maxnet_controller #(
    parameter int N_PU     = 4,
    parameter int MAX_ITER = 16,
    parameter int SUM_WAIT = 0,
    localparam int WIN_W   = (N_PU > 1) ? $clog2(N_PU) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_PU-1:0][31:0]  x_init,
    input  logic [N_PU-1:0][31:0]  pu_out,
    input  logic [N_PU-1:0]        pu_s,
    output logic [N_PU-1:0][31:0]  pu_x,
    output logic                   load_mult,
    output logic                   load_sum,
    output logic                   busy,
    output logic                   done,
    output logic [WIN_W-1:0]       winner,
    output logic                   winner_valid,
    output logic                   timeout,
    output logic [7:0]             iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_WAIT,
        S_SUM,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] MAX_ITER_V = 8'(MAX_ITER);
    localparam logic [2:0] WAIT_LAST  = (SUM_WAIT > 0) ? 3'(SUM_WAIT - 1) : 3'd0;

    state_t                  state_q, state_d;
    logic [2:0]              wait_cnt_q, wait_cnt_d;
    logic [N_PU-1:0][31:0]   pu_x_q, pu_x_d;
    logic                    load_mult_q, load_mult_d;
    logic                    load_sum_q, load_sum_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WIN_W-1:0]        winner_q, winner_d;
    logic                    winner_valid_q, winner_valid_d;
    logic                    timeout_q, timeout_d;
    logic [7:0]              iter_count_q, iter_count_d;

    logic [7:0]              active_cnt;
    logic [WIN_W-1:0]        active_idx;
    logic [7:0]              iter_next;

    assign iter_next = iter_count_q + 8'd1;

    // Only a definite 1 counts as active, so unknown s bits read as suppressed.
    always_comb begin
        active_cnt = '0;
        active_idx = '0;
        for (int i = 0; i < N_PU; i++) begin
            if (pu_s[i] == 1'b1) begin
                active_cnt = active_cnt + 8'd1;
                active_idx = WIN_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MULT;
            S_MULT:  state_d = (SUM_WAIT == 0) ? S_SUM : S_WAIT;
            S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_SUM;
            S_SUM:   state_d = S_CHECK;
            S_CHECK: begin
                if (active_cnt <= 8'd1 || iter_next == MAX_ITER_V) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses and busy are decoded from the next state so they appear registered.
    always_comb begin
        load_mult_d    = (state_d == S_MULT);
        load_sum_d     = (state_d == S_SUM);
        busy_d         = (state_d == S_MULT) || (state_d == S_WAIT) ||
                         (state_d == S_SUM)  || (state_d == S_CHECK);
        done_d         = (state_d == S_DONE);
        wait_cnt_d     = wait_cnt_q;
        pu_x_d         = pu_x_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        timeout_d      = timeout_q;
        iter_count_d   = iter_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pu_x_d         = x_init;
                    iter_count_d   = '0;
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                end
            end
            S_MULT:  wait_cnt_d = '0;
            S_WAIT:  wait_cnt_d = wait_cnt_q + 3'd1;
            S_CHECK: begin
                iter_count_d = iter_next;
                if (active_cnt == 8'd1) begin
                    winner_d       = active_idx;
                    winner_valid_d = 1'b1;
                end else if (active_cnt == 8'd0) begin
                    winner_valid_d = 1'b0;
                end else if (iter_next == MAX_ITER_V) begin
                    timeout_d = 1'b1;
                end else begin
                    pu_x_d = pu_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q     <= '0;
            pu_x_q         <= '0;
            load_mult_q    <= 1'b0;
            load_sum_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            iter_count_q   <= '0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            pu_x_q         <= pu_x_d;
            load_mult_q    <= load_mult_d;
            load_sum_q     <= load_sum_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            timeout_q      <= timeout_d;
            iter_count_q   <= iter_count_d;
        end
    end

    assign pu_x         = pu_x_q;
    assign load_mult    = load_mult_q;
    assign load_sum     = load_sum_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign timeout      = timeout_q;
    assign iter_count   = iter_count_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: two instances (MAX_ITER=4/SUM_WAIT=0 and MAX_ITER=6/SUM_WAIT=2)
// driven by scripted PU stubs and compared every cycle against a schedule-level model.
module tb_maxnet_controller;

    localparam int N  = 4;
    localparam int NI = 2;
    localparam int NP = 8;

    int max_iter[NI] = '{4, 6};
    int sum_wait[NI] = '{0, 2};

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start_v[NI];
    logic [N-1:0][31:0]  x_init_v[NI];
    logic [N-1:0][31:0]  pu_out_v[NI];
    logic [N-1:0]        pu_s_v[NI];
    logic [N-1:0][31:0]  pu_x_v[NI];
    logic                lm_v[NI], ls_v[NI], busy_v[NI], done_v[NI], wv_v[NI], to_v[NI];
    logic [1:0]          win_v[NI];
    logic [7:0]          it_v[NI];

    int checks   = 0;
    int failures = 0;

    // Programmed stub responses: pending ones are adopted when a start is accepted.
    logic [N-1:0]        pend_s[NI][NP];
    logic [N-1:0][31:0]  pend_out[NI][NP];
    logic [N-1:0]        act_s[NI][NP];
    logic [N-1:0][31:0]  act_out[NI][NP];
    logic [N-1:0][31:0]  act_x[NI];

    int         running[NI];
    int         rel[NI];
    int         n_it[NI];
    logic       exp_wv[NI], exp_to[NI];
    logic [1:0] exp_win[NI];
    int         sum_cnt[NI];
    int         ls_total[NI] = '{0, 0};

    always #5 clock = ~clock;

    maxnet_controller #(.N_PU(N), .MAX_ITER(4), .SUM_WAIT(0)) dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .x_init(x_init_v[0]),
        .pu_out(pu_out_v[0]), .pu_s(pu_s_v[0]), .pu_x(pu_x_v[0]),
        .load_mult(lm_v[0]), .load_sum(ls_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .winner(win_v[0]), .winner_valid(wv_v[0]), .timeout(to_v[0]), .iter_count(it_v[0])
    );

    maxnet_controller #(.N_PU(N), .MAX_ITER(6), .SUM_WAIT(2)) dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .x_init(x_init_v[1]),
        .pu_out(pu_out_v[1]), .pu_s(pu_s_v[1]), .pu_x(pu_x_v[1]),
        .load_mult(lm_v[1]), .load_sum(ls_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .winner(win_v[1]), .winner_valid(wv_v[1]), .timeout(to_v[1]), .iter_count(it_v[1])
    );

    // PU stub: after the k-th load_sum it presents the k-th programmed response.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            if (sum_cnt[i] >= 1 && sum_cnt[i] <= NP) begin
                pu_s_v[i]   = act_s[i][sum_cnt[i]-1];
                pu_out_v[i] = act_out[i][sum_cnt[i]-1];
            end else begin
                pu_s_v[i]   = '1;
                pu_out_v[i] = '1;
            end
        end
    end

    // Model: on an accepted start, work out iteration count and final result from the program.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                running[i] = 0;
                rel[i]     = 0;
                n_it[i]    = 0;
                exp_wv[i]  = 1'b0;
                exp_to[i]  = 1'b0;
                exp_win[i] = '0;
                sum_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int per;
                int pc;
                per = 3 + sum_wait[i];
                if (ls_v[i]) ls_total[i]++;
                if (start_v[i] && (running[i] == 0 || rel[i] >= n_it[i] * per + 2)) begin
                    running[i] = 1;
                    rel[i]     = 1;
                    act_x[i]   <= x_init_v[i];
                    for (int k = 0; k < NP; k++) begin
                        act_s[i][k]   <= pend_s[i][k];
                        act_out[i][k] <= pend_out[i][k];
                    end
                    sum_cnt[i] <= 0;
                    n_it[i]    = 0;
                    exp_wv[i]  = 1'b0;
                    exp_to[i]  = 1'b0;
                    exp_win[i] = '0;
                    for (int k = 0; k < max_iter[i]; k++) begin
                        pc      = $countones(pend_s[i][k]);
                        n_it[i] = k + 1;
                        if (pc == 1) begin
                            exp_wv[i] = 1'b1;
                            for (int j = 0; j < N; j++)
                                if (pend_s[i][k][j]) exp_win[i] = 2'(j);
                            break;
                        end
                        if (pc == 0) break;
                        if (n_it[i] == max_iter[i]) exp_to[i] = 1'b1;
                    end
                end else begin
                    if (running[i] != 0) rel[i]++;
                    if (ls_v[i]) sum_cnt[i] <= sum_cnt[i] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d t=%0t actual=%0h required=%0h",
                     name, inst, $time, act, req);
        end
    endtask

    // Compare every output of every instance on each falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            int per, r, n, k;
            logic in_busy, e_lm, e_ls, e_done, e_wv, e_to;
            logic [1:0] e_win;
            logic [7:0] e_it;
            per = 3 + sum_wait[i];
            r = rel[i];
            n = n_it[i];
            in_busy = (running[i] != 0) && r >= 1 && r <= n * per;
            e_lm   = in_busy && ((r - 1) % per == 0);
            e_ls   = in_busy && ((r - 1) % per == sum_wait[i] + 1);
            e_done = (running[i] != 0) && (r == n * per + 1);
            if (running[i] == 0 || in_busy) begin
                e_win = '0;
                e_wv  = 1'b0;
                e_to  = 1'b0;
                e_it  = (running[i] == 0) ? 8'd0 : 8'((r - 1) / per);
            end else begin
                e_win = exp_win[i];
                e_wv  = exp_wv[i];
                e_to  = exp_to[i];
                e_it  = 8'(n);
            end
            checkOutput("load_mult", i, 128'(lm_v[i]), 128'(e_lm));
            checkOutput("load_sum", i, 128'(ls_v[i]), 128'(e_ls));
            checkOutput("loads_exclusive", i, 128'(lm_v[i] & ls_v[i]), 128'(0));
            checkOutput("busy", i, 128'(busy_v[i]), 128'(in_busy));
            checkOutput("done", i, 128'(done_v[i]), 128'(e_done));
            checkOutput("winner", i, 128'(win_v[i]), 128'(e_win));
            checkOutput("winner_valid", i, 128'(wv_v[i]), 128'(e_wv));
            checkOutput("timeout", i, 128'(to_v[i]), 128'(e_to));
            checkOutput("iter_count", i, 128'(it_v[i]), 128'(e_it));
            if (running[i] == 0) begin
                checkOutput("pu_x_idle", i, 128'(pu_x_v[i]), 128'(0));
            end else if (e_lm) begin
                k = (r - 1) / per;
                checkOutput("pu_x_mult", i, 128'(pu_x_v[i]),
                            (k == 0) ? 128'(act_x[i]) : 128'(act_out[i][k-1]));
            end
        end
    end

    task automatic applyStimulus(input int inst, input logic [N-1:0][31:0] x,
                                 input logic [N-1:0] s0, input logic [N-1:0] s1,
                                 input logic [N-1:0] s2, input logic [N-1:0] s3);
        x_init_v[inst] = x;
        for (int k = 0; k < NP; k++) begin
            case (k)
                0:       pend_s[inst][k] = s0;
                1:       pend_s[inst][k] = s1;
                2:       pend_s[inst][k] = s2;
                default: pend_s[inst][k] = s3;
            endcase
            for (int j = 0; j < N; j++) pend_out[inst][k][j] = $urandom;
        end
    endtask

    // Pulses start, re-pulses it at cycle extra_c while busy, returns the done cycle.
    task automatic runTxn(input int inst, input int extra_c, output int done_c);
        @(negedge clock);
        start_v[inst] = 1'b1;
        done_c = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            start_v[inst] = (c == extra_c);
            if (done_v[inst]) begin
                done_c = c;
                break;
            end
        end
        start_v[inst] = 1'b0;
        if (done_c < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_wait inst=%0d actual=no_done required=done", inst);
        end
    endtask

    function automatic logic [N-1:0] rand_s();
        logic [N-1:0] v;
        int r;
        r = $urandom_range(0, 11);
        v = '0;
        if (r < 2) begin
            v[$urandom_range(0, N-1)] = 1'b1;
        end else if (r > 2) begin
            do v = N'($urandom); while ($countones(v) < 2);
        end
        return v;
    endfunction

    logic [N-1:0][31:0] x_a;
    int dc, snap;

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_v[i]  = 1'b0;
            x_init_v[i] = '0;
        end
        x_a = {32'h3F800000, 32'h3F000000, 32'h0, 32'h0};
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(0, x_a, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        runTxn(0, 2, dc);
        checkOutput("s1_done_cycle", 0, 128'(dc), 128'(4));
        checkOutput("s1_winner", 0, 128'(win_v[0]), 128'(2));
        checkOutput("s1_winner_valid", 0, 128'(wv_v[0]), 128'(1));
        checkOutput("s1_iter_count", 0, 128'(it_v[0]), 128'(1));

        applyStimulus(0, x_a, 4'b1011, 4'b0011, 4'b0010, 4'b0010);
        runTxn(0, 2, dc);
        checkOutput("s2_done_cycle", 0, 128'(dc), 128'(10));
        checkOutput("s2_winner", 0, 128'(win_v[0]), 128'(1));
        checkOutput("s2_iter_count", 0, 128'(it_v[0]), 128'(3));

        applyStimulus(0, x_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        runTxn(0, 3, dc);
        checkOutput("s3_winner_valid", 0, 128'(wv_v[0]), 128'(0));
        checkOutput("s3_timeout", 0, 128'(to_v[0]), 128'(0));
        checkOutput("s3_iter_count", 0, 128'(it_v[0]), 128'(1));

        snap = ls_total[0];
        applyStimulus(0, x_a, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        runTxn(0, 2, dc);
        @(negedge clock);
        checkOutput("s4_load_sum_pulses", 0, 128'(ls_total[0] - snap), 128'(4));
        checkOutput("s4_done_cycle", 0, 128'(dc), 128'(13));
        checkOutput("s4_timeout", 0, 128'(to_v[0]), 128'(1));
        checkOutput("s4_winner_valid", 0, 128'(wv_v[0]), 128'(0));
        checkOutput("s4_iter_count", 0, 128'(it_v[0]), 128'(4));

        applyStimulus(1, x_a, 4'b0110, 4'b1000, 4'b1000, 4'b1000);
        runTxn(1, 3, dc);
        checkOutput("s5_done_cycle", 1, 128'(dc), 128'(11));
        checkOutput("s5_winner", 1, 128'(win_v[1]), 128'(3));
        checkOutput("s5_iter_count", 1, 128'(it_v[1]), 128'(2));

        applyStimulus(0, x_a, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        @(negedge clock);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        checkOutput("s6_load_mult_before", 0, 128'(lm_v[0]), 128'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("s6_load_mult_reset", 0, 128'(lm_v[0]), 128'(0));
        checkOutput("s6_busy_reset", 0, 128'(busy_v[0]), 128'(0));
        checkOutput("s6_pu_x_reset", 0, 128'(pu_x_v[0]), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        snap = ls_total[0];
        repeat (6) @(negedge clock);
        checkOutput("s6_no_load_sum", 0, 128'(ls_total[0] - snap), 128'(0));
        runTxn(0, 2, dc);
        checkOutput("s6_done_cycle", 0, 128'(dc), 128'(4));
        checkOutput("s6_iter_count", 0, 128'(it_v[0]), 128'(1));

        for (int t = 0; t < 24; t++) begin
            int inst;
            inst = t % 2;
            for (int j = 0; j < N; j++) x_init_v[inst][j] = $urandom;
            for (int k = 0; k < NP; k++) begin
                pend_s[inst][k] = rand_s();
                for (int j = 0; j < N; j++) pend_out[inst][k][j] = $urandom;
            end
            runTxn(inst, $urandom_range(2, 2 + sum_wait[inst]), dc);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
